// File: rtl/simon_ct_serializer_if.sv
// Byte-stream and ciphertext-capture bundle for simon_ct_serializer.
// The slave modport is the serializer's view; master is the environment
// that produces ciphertext and consumes bytes.
interface simon_ct_serializer_if;
  logic        ct_done;
  logic [31:0] ct_word;
  logic        byte_ready;
  logic        byte_valid;
  logic [7:0]  byte_data;

  modport master (
    output ct_done,
    output ct_word,
    output byte_ready,
    input  byte_valid,
    input  byte_data
  );

  modport slave (
    input  ct_done,
    input  ct_word,
    input  byte_ready,
    output byte_valid,
    output byte_data
  );
endinterface

// File: rtl/simon_ct_serializer.sv
// Captures one 32-bit ciphertext per rising edge of ct_done into a small
// FIFO and streams each word out MSB-first as four bytes over a
// valid/ready byte interface. Words arriving at a full FIFO are dropped
// and flagged in a sticky overflow bit.
module simon_ct_serializer #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  simon_ct_serializer_if.slave       bus,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  // FIFO storage and pointers
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          ct_done_d;

  // Serializer state
  state_t        state;
  logic [1:0]    idx;
  logic [31:0]   shreg;
  logic          byte_valid_q;
  logic [7:0]    byte_data_q;

  // Per-cycle decisions
  logic          push_edge;
  logic          handshake;
  logic          pop;
  logic          push;
  logic          drop;
  logic [31:0]   head;

  // Byte lane selection, MSB first.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Decide push/pop/drop for this edge; pops see the count before any push.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and no latch is inferred.
    push_edge = 1'b0;
    handshake = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;
    drop      = 1'b0;
    head      = mem[rd_ptr];

    push_edge = bus.ct_done && !ct_done_d;
    handshake = byte_valid_q && bus.byte_ready;

    if (!clear && fifo_count != '0) begin
      if (state == S_IDLE)
        pop = 1'b1;
      else if (handshake && idx == 2'd3)
        pop = 1'b1;
    end

    if (push_edge && !clear) begin
      if (fifo_count != FULL_COUNT || pop)
        push = 1'b1;
      else
        drop = 1'b1;
    end
  end

  // Pointers, occupancy, overflow flag and completion-edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      ct_done_d  <= 1'b0;
    end else begin
      // Tracks ct_done even during clear, so a level held across clear is not a new edge.
      ct_done_d <= bus.ct_done;
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        overflow   <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + 1'b1;
          2'b01:   fifo_count <= fifo_count - 1'b1;
          default: fifo_count <= fifo_count;
        endcase
        if (drop)
          overflow <= 1'b1;
      end
    end
  end

  // FIFO storage write; a simultaneous pop at full reads the old entry.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; pointers and count alone define which entries are live.
    if (push)
      mem[wr_ptr] <= bus.ct_word;
  end

  // Serializer FSM: loads a word from the FIFO and presents it byte by byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= 2'd0;
      shreg        <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
    end else if (clear) begin
      state        <= S_IDLE;
      idx          <= 2'd0;
      shreg        <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg        <= head;
            idx          <= 2'd0;
            byte_valid_q <= 1'b1;
            byte_data_q  <= head[31:24];
            state        <= S_SEND;
          end
        end
        S_SEND: begin
          if (handshake) begin
            if (idx != 2'd3) begin
              idx         <= idx + 2'd1;
              byte_data_q <= byte_sel(shreg, idx + 2'd1);
            end else if (pop) begin
              // Next word follows with no idle cycle.
              shreg       <= head;
              idx         <= 2'd0;
              byte_data_q <= head[31:24];
            end else begin
              idx          <= 2'd0;
              byte_valid_q <= 1'b0;
              byte_data_q  <= '0;
              state        <= S_IDLE;
            end
          end
        end
        default: begin
          state        <= S_IDLE;
          byte_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;

endmodule

// File: tb/tb_simon_ct_serializer.sv
// Directed bench for simon_ct_serializer: latency, backpressure, level
// ct_done, overflow with push/pop at full, back-to-back streaming with
// pointer wrap, clear and asynchronous reset.
module tb_simon_ct_serializer;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];

  simon_ct_serializer_if bus ();

  simon_ct_serializer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bus        (bus.slave),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One ct_done pulse (rising edge at the first clock) then a quiet cycle.
  task automatic push_word(input logic [31:0] w);
    bus.ct_word = w;
    bus.ct_done = 1'b1;
    step();
    bus.ct_done = 1'b0;
    step();
  endtask

  // Record any byte handed over at the coming edge, then advance.
  task automatic collect(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if (bus.byte_valid && bus.byte_ready)
        got_q.push_back(bus.byte_data);
      step();
    end
  endtask

  task automatic add_exp(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic compare_q(input string tag);
    int n;
    check({tag, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [31:0] ow(input int i);
    return 32'h10203040 + (32'h01010101 * 32'(i));
  endfunction

  initial begin
    logic [31:0] w;
    int          peak;

    bus.ct_done    = 1'b0;
    bus.ct_word    = '0;
    bus.byte_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_valid", bus.byte_valid, 1'b0);
    check("rst_data", bus.byte_data, 8'h00);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;
    step();

    // Single word, latency and byte order
    bus.byte_ready = 1'b1;
    bus.ct_word = 32'h1234ABCD;
    bus.ct_done = 1'b1;
    step();
    bus.ct_done = 1'b0;
    check("lat_valid_n", bus.byte_valid, 1'b0);
    check("lat_count_n", fifo_count, 1);
    step();
    check("lat_valid_n1", bus.byte_valid, 1'b1);
    check("single_b0", bus.byte_data, 8'h12);
    check("lat_count_n1", fifo_count, 0);
    step();
    check("single_b1", bus.byte_data, 8'h34);
    step();
    check("single_b2", bus.byte_data, 8'hAB);
    step();
    check("single_b3", bus.byte_data, 8'hCD);
    check("single_v3", bus.byte_valid, 1'b1);
    step();
    check("single_end", bus.byte_valid, 1'b0);

    // Backpressure mid-word
    push_word(32'hA1B2C3D4);
    check("bp_b0", bus.byte_data, 8'hA1);
    step();
    check("bp_b1", bus.byte_data, 8'hB2);
    bus.byte_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_hold_data", bus.byte_data, 8'hB2);
      check("bp_hold_valid", bus.byte_valid, 1'b1);
    end
    bus.byte_ready = 1'b1;
    step();
    check("bp_b2", bus.byte_data, 8'hC3);
    step();
    check("bp_b3", bus.byte_data, 8'hD4);
    step();
    check("bp_end", bus.byte_valid, 1'b0);

    // Level ct_done held 10 cycles: one word only
    bus.ct_word = 32'hDEADBEEF;
    peak = 0;
    for (int c = 0; c < 16; c++) begin
      bus.ct_done = (c < 10);
      collect(1);
      if (int'(fifo_count) > peak)
        peak = int'(fifo_count);
    end
    bus.ct_done = 1'b0;
    add_exp(32'hDEADBEEF);
    compare_q("level_byte");
    check("level_peak", peak, 1);

    // Overflow: DEPTH+2 pushes with the sink stalled
    bus.byte_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++)
      push_word(ow(i));
    check("ovf_count", fifo_count, DEPTH);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_valid", bus.byte_valid, 1'b1);
    w = ow(0);
    check("ovf_head", bus.byte_data, w[31:24]);
    // Drain; a push lands on the same edge as the pop of word 1 while full.
    bus.byte_ready = 1'b1;
    collect(3);
    bus.ct_word = 32'hC0FFEE55;
    bus.ct_done = 1'b1;
    collect(1);
    bus.ct_done = 1'b0;
    check("full_pushpop_count", fifo_count, DEPTH);
    w = ow(1);
    check("full_pushpop_head", bus.byte_data, w[31:24]);
    collect(40);
    for (int i = 0; i <= DEPTH; i++)
      add_exp(ow(i));
    add_exp(32'hC0FFEE55);
    compare_q("ovf_drain");
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_drained", fifo_count, 0);

    // Clear releases overflow
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_ovf", overflow, 1'b0);
    check("clr_count", fifo_count, 0);

    // Back-to-back: 3 queued words stream with no idle cycle
    bus.byte_ready = 1'b0;
    push_word(32'h01020304);
    push_word(32'h05060708);
    push_word(32'h090A0B0C);
    check("b2b_count", fifo_count, 2);
    bus.byte_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check("b2b_valid", bus.byte_valid, 1'b1);
      check("b2b_data", bus.byte_data, 8'(k + 1));
      step();
    end
    check("b2b_end", bus.byte_valid, 1'b0);

    // Pointer wrap: 13 more words (16 since clear) while draining
    for (int c = 0; c < 63; c++) begin
      bus.ct_done = (c % 3 == 0) && (c / 3 < 13);
      bus.ct_word = 32'hF0E1D2C3 ^ (32'h00010001 * 32'(c / 3));
      collect(1);
    end
    bus.ct_done = 1'b0;
    for (int i = 0; i < 13; i++)
      add_exp(32'hF0E1D2C3 ^ (32'h00010001 * 32'(i)));
    compare_q("wrap_byte");
    check("wrap_count", fifo_count, 0);

    // Clear mid-word with a same-cycle push and ct_done held across it
    bus.byte_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++)
      push_word(32'h5A000000 | 32'(i));
    check("clr_pre_ovf", overflow, 1'b1);
    bus.byte_ready = 1'b1;
    step();
    bus.byte_ready = 1'b0;
    check("clr_midword", bus.byte_data, 8'h00);
    clear = 1'b1;
    bus.ct_word = 32'h77777777;
    bus.ct_done = 1'b1;
    step();
    clear = 1'b0;
    check("clr_valid", bus.byte_valid, 1'b0);
    check("clr_count2", fifo_count, 0);
    check("clr_ovf2", overflow, 1'b0);
    step();
    step();
    step();
    check("clr_held_count", fifo_count, 0);
    check("clr_held_valid", bus.byte_valid, 1'b0);
    bus.ct_done = 1'b0;
    step();

    // Asynchronous reset mid-word
    bus.byte_ready = 1'b0;
    push_word(32'h9ABCDEF0);
    check("rstmid_pre", bus.byte_data, 8'h9A);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", bus.byte_valid, 1'b0);
    check("rstmid_data", bus.byte_data, 8'h00);
    check("rstmid_count", fifo_count, 0);
    step();
    rst_n = 1'b1;
    bus.byte_ready = 1'b1;
    step();
    step();
    step();
    check("rstmid_abandon", bus.byte_valid, 1'b0);

    // ct_done already high at reset release counts as a rising edge
    rst_n = 1'b0;
    bus.ct_word = 32'h3C4D5E6F;
    bus.ct_done = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    check("rel_count", fifo_count, 1);
    step();
    check("rel_valid", bus.byte_valid, 1'b1);
    check("rel_data", bus.byte_data, 8'h3C);
    bus.ct_done = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
